esram_arbiter: RTL

Round-robin arbiter and transaction sequencer for the shared eSRAM port on the fast 184.333 MHz `clk` domain. It accepts full request/acknowledge transactions from up to `NUM_REQ` masters, such as the i8080 bus bridge and the loader/DMA. It serialises them into single-pulse commands for the clock-domain coupler toward the AHB master, then returns completion and read data to the winning master. It replaces fixed-priority muxing with fair, one-outstanding-transaction sequencing.

---
 rtl/esram_pkg.sv | 15 +
 rtl/rr_pick.sv | 30 +++
 rtl/esram_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/esram_pkg.sv
// Shared types and widths for the eSRAM port arbiter and its helpers.
package esram_pkg;

    localparam int ESRAM_AW = 16;
    localparam int ESRAM_DW = 8;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        ARM,
        WAIT,
        DONE
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first requester after i_last, cyclic.
module rr_pick #(
    parameter int N  = 2,
    parameter int LW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [LW-1:0] i_last,
    output logic [N-1:0]  o_gnt,
    output logic          o_any
);

    int   idx;
    logic found;

    always_comb begin
        o_gnt = '0;
        o_any = |i_req;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = int'(i_last) + k;
            if (idx >= N) idx = idx - N;
            if (!found && i_req[idx]) begin
                o_gnt[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/esram_arbiter.sv
// Round-robin sequencer for the shared eSRAM port, one transaction in flight.
// Optional macro ESRAM_ARB_TIMEOUT_EN adds the WAIT timeout and err output.
module esram_arbiter
    import esram_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          we,
    input  logic [NUM_REQ*ESRAM_AW-1:0] addr,
    input  logic [NUM_REQ*ESRAM_DW-1:0] wdata,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [NUM_REQ-1:0]          done,
    output logic                        err,
    output logic [ESRAM_DW-1:0]         rdata,
    output logic [ESRAM_AW-1:0]         mem_addr,
    output logic [ESRAM_DW-1:0]         mem_wdata,
    output logic                        mem_write,
    output logic                        mem_read,
    input  logic                        mem_busy,
    input  logic                        mem_valid,
    input  logic [ESRAM_DW-1:0]         mem_rdata
);

    localparam int LW = $clog2(NUM_REQ);

    arb_state_t          r_state;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [NUM_REQ-1:0]  r_done;
    logic [LW-1:0]       r_last;
    logic [ESRAM_DW-1:0] r_rdata;
    logic [ESRAM_AW-1:0] r_mem_addr;
    logic [ESRAM_DW-1:0] r_mem_wdata;
    logic                r_mem_write;
    logic                r_mem_read;
    logic                r_valid_q;

    logic [NUM_REQ-1:0]  w_pick;
    logic                w_any;
    logic [LW-1:0]       w_idx;
    logic                w_we;
    logic                w_edge;

`ifdef ESRAM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_err;
    assign w_cnt_nxt = r_cnt + 1'b1;
    assign err       = r_err;
`else
    logic w_unused_to;
    assign w_unused_to = ^TIMEOUT_CYCLES;
    assign err         = 1'b0;
`endif

    rr_pick #(.N(NUM_REQ), .LW(LW)) u_pick (
        .i_req  (req),
        .i_last (r_last),
        .o_gnt  (w_pick),
        .o_any  (w_any)
    );

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick[i]) w_idx = LW'(i);
        end
    end

    assign w_we   = we[w_idx];
    assign w_edge = mem_valid && !r_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_done      <= '0;
            r_last      <= LW'(NUM_REQ - 1);
            r_rdata     <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_valid_q   <= 1'b0;
`ifdef ESRAM_ARB_TIMEOUT_EN
            r_cnt       <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            r_valid_q   <= mem_valid;
            r_mem_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_done      <= '0;
            unique case (r_state)
                IDLE: begin
                    if (w_any && !mem_busy) begin
                        r_state     <= ISSUE;
                        r_gnt       <= w_pick;
                        r_last      <= w_idx;
                        r_mem_addr  <= addr[w_idx*ESRAM_AW +: ESRAM_AW];
                        r_mem_wdata <= wdata[w_idx*ESRAM_DW +: ESRAM_DW];
                        r_mem_write <= w_we;
                        r_mem_read  <= !w_we;
                    end
                end
                ISSUE: r_state <= ARM;
                // a valid level left over from the last access must drop first
                ARM: begin
                    if (!mem_valid) begin
                        r_state <= WAIT;
`ifdef ESRAM_ARB_TIMEOUT_EN
                        r_cnt   <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (w_edge) begin
                        r_state <= DONE;
                        r_rdata <= mem_rdata;
                        r_done  <= r_gnt;
`ifdef ESRAM_ARB_TIMEOUT_EN
                    end else if (w_cnt_nxt == CW'(TIMEOUT_CYCLES)) begin
                        r_state <= DONE;
                        r_done  <= r_gnt;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt   <= w_cnt_nxt;
`endif
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_gnt   <= '0;
`ifdef ESRAM_ARB_TIMEOUT_EN
                    r_err   <= 1'b0;
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign done      = r_done;
    assign rdata     = r_rdata;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_write = r_mem_write;
    assign mem_read  = r_mem_read;

endmodule
